// File: rtl/calpart_sequencer.sv
// calpart_sequencer
//   Microprogrammed control sequencer for the CalPart datapath. A host loads
//   16-bit instructions into a small program memory, pulses Start, and waits
//   for Done. Each instruction takes two cycles: FETCH loads the instruction
//   register and advances PC, and EXEC presents the decoded control word to
//   the datapath. Conditional branches look at the datapath zero flag Q.
//
//   Optional feature macro: CALPART_SEQ_SINGLE_STEP_EN
//     Adds StepMode/Step inputs and a PAUSE state. With StepMode=1 every
//     non-HALT EXEC parks in PAUSE until a Step pulse.
//
//   Ports
//     Clock, Reset_n        rising-edge clock, asynchronous active-low reset
//     ProgWE/Addr/Data      program memory write port (ignored while Busy)
//     Start                 single-cycle pulse, begins execution at address 0
//     Q                     datapath zero flag
//     IE ZE OE WE RAE RBE   datapath control strobes (EXEC only)
//     WA RAA RBA OP         register addresses / ALU op (EXEC only)
//     Cal_value             ALU immediate (EXEC only)
//     Busy                  high in FETCH/EXEC (and PAUSE)
//     Done                  one-cycle pulse in the HALTED state
//     PC                    program counter (debug)
//     StepMode, Step        single-step controls (macro builds only)
//
//   Instruction: [15:13] class, [12:11] WA, [10:9] RAA, [8:7] RBA,
//                [6:4] OP, [3:0] Cal_value; jump target = [PC_WIDTH-1:0].
module calpart_sequencer #(
  parameter int PC_WIDTH = 4
) (
  input  logic                Clock,
  input  logic                Reset_n,
  input  logic                ProgWE,
  input  logic [PC_WIDTH-1:0] ProgAddr,
  input  logic [15:0]         ProgData,
  input  logic                Start,
  input  logic                Q,
`ifdef CALPART_SEQ_SINGLE_STEP_EN
  input  logic                StepMode,
  input  logic                Step,
`endif
  output logic                IE,
  output logic                ZE,
  output logic                OE,
  output logic                WE,
  output logic                RAE,
  output logic                RBE,
  output logic [1:0]          WA,
  output logic [1:0]          RAA,
  output logic [1:0]          RBA,
  output logic [2:0]          OP,
  output logic [3:0]          Cal_value,
  output logic                Busy,
  output logic                Done,
  output logic [PC_WIDTH-1:0] PC
);

  localparam int DEPTH = 1 << PC_WIDTH;

  localparam logic [2:0] CLS_NOP  = 3'b000;
  localparam logic [2:0] CLS_IN   = 3'b001;
  localparam logic [2:0] CLS_ALU  = 3'b010;
  localparam logic [2:0] CLS_OUT  = 3'b011;
  localparam logic [2:0] CLS_JMP  = 3'b100;
  localparam logic [2:0] CLS_JZ   = 3'b101;
  localparam logic [2:0] CLS_JNZ  = 3'b110;
  localparam logic [2:0] CLS_HALT = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_EXEC   = 3'd2,
    S_HALTED = 3'd3
`ifdef CALPART_SEQ_SINGLE_STEP_EN
    , S_PAUSE = 3'd4
`endif
  } state_t;

  state_t                state;
  logic [2:0]            ir_class;
  logic [PC_WIDTH-1:0]   ir_target;
  logic [15:0]           mem [DEPTH];
  logic [15:0]           fetch_word;

  // Strobe pattern {IE, ZE, OE, WE, RAE, RBE} for an instruction class.
  function automatic logic [5:0] decode_strobes(input logic [2:0] cls);
    logic [5:0] s;
    s = 6'b000000;
    case (cls)
      CLS_IN:  s = 6'b100100;
      CLS_ALU: s = 6'b010111;
      CLS_OUT: s = 6'b001011;
      default: s = 6'b000000;
    endcase
    return s;
  endfunction

  // Program memory is never reset; writes are locked out while running.
  always_ff @(posedge Clock) begin
    if (ProgWE && !Busy) mem[ProgAddr] <= ProgData;
  end

  assign fetch_word = mem[PC];

  // The control word is registered at the FETCH->EXEC edge from the word
  // being fetched and cleared at every other edge, so it is exactly the
  // decode of IR during EXEC and zero everywhere else.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= S_IDLE;
      PC        <= '0;
      ir_class  <= '0;
      ir_target <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      {IE, ZE, OE, WE, RAE, RBE} <= 6'b000000;
      WA        <= '0;
      RAA       <= '0;
      RBA       <= '0;
      OP        <= '0;
      Cal_value <= '0;
    end else begin
      Done      <= 1'b0;
      {IE, ZE, OE, WE, RAE, RBE} <= 6'b000000;
      WA        <= '0;
      RAA       <= '0;
      RBA       <= '0;
      OP        <= '0;
      Cal_value <= '0;

      case (state)
        S_IDLE: begin
          if (Start) begin
            PC    <= '0;
            Busy  <= 1'b1;
            state <= S_FETCH;
          end
        end

        S_FETCH: begin
          ir_class  <= fetch_word[15:13];
          ir_target <= fetch_word[PC_WIDTH-1:0];
          PC        <= PC + PC_WIDTH'(1);
          {IE, ZE, OE, WE, RAE, RBE} <= decode_strobes(fetch_word[15:13]);
          WA        <= fetch_word[12:11];
          RAA       <= fetch_word[10:9];
          RBA       <= fetch_word[8:7];
          OP        <= fetch_word[6:4];
          Cal_value <= fetch_word[3:0];
          state     <= S_EXEC;
        end

        S_EXEC: begin
          case (ir_class)
            CLS_JMP: PC <= ir_target;
            CLS_JZ:  if (Q)  PC <= ir_target;
            CLS_JNZ: if (!Q) PC <= ir_target;
            default: ;
          endcase
          if (ir_class == CLS_HALT) begin
            Busy  <= 1'b0;
            Done  <= 1'b1;
            state <= S_HALTED;
          end else begin
`ifdef CALPART_SEQ_SINGLE_STEP_EN
            state <= StepMode ? S_PAUSE : S_FETCH;
`else
            state <= S_FETCH;
`endif
          end
        end

        S_HALTED: begin
          state <= S_IDLE;
        end

`ifdef CALPART_SEQ_SINGLE_STEP_EN
        S_PAUSE: begin
          if (Step) state <= S_FETCH;
        end
`endif

        default: begin
          Busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
